// File: rtl/efb_wb_arb_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | efb_wb_arb_pkg : shared EFB constants for the wishbone arbiter          |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package efb_wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  // m1 counts as "served last" out of reset so m0 wins the first tie
  localparam logic RR_RESET = OWNER_M1;

  localparam int unsigned EFB_WB_ARB_TMO_DEFAULT = 255;

endpackage
`default_nettype wire

// File: rtl/efb_wb_arb.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | efb_wb_arb : two-requester round-robin arbiter for the EFB wishbone port |
// | Optional strobe timeout abort enabled by EFB_WB_ARB_TIMEOUT_EN.          |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module efb_wb_arb
  import efb_wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = EFB_WB_ARB_TMO_DEFAULT
) (
  input  logic       xclk,
  input  logic       rst_n,
  input  logic       m0_cyc,
  input  logic       m0_stb,
  input  logic       m0_we,
  input  logic [7:0] m0_adr,
  input  logic [7:0] m0_dat_i,
  output logic [7:0] m0_dat_o,
  output logic       m0_ack,
  output logic       m0_err,
  input  logic       m1_cyc,
  input  logic       m1_stb,
  input  logic       m1_we,
  input  logic [7:0] m1_adr,
  input  logic [7:0] m1_dat_i,
  output logic [7:0] m1_dat_o,
  output logic       m1_ack,
  output logic       m1_err,
  output logic       s_cyc,
  output logic       s_stb,
  output logic       s_we,
  output logic [7:0] s_adr,
  output logic [7:0] s_dat_o,
  input  logic [7:0] s_dat_i,
  input  logic       s_ack,
  output logic [1:0] gnt
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("efb_wb_arb: TIMEOUT_CYCLES must be in 2..255");
  end

  arb_state_e state_q, state_d;
  logic       rr_q, rr_d;
  logic       pick;
  logic [1:0] req;
  logic       tmo_hit;
  logic       own_cyc, own_stb, own_we;
  logic [7:0] own_adr, own_dat;

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = 8'h00;
    own_dat = 8'h00;
    case (state_q)
      ARB_OWN0: begin
        own_cyc = m0_cyc;
        own_stb = m0_stb;
        own_we  = m0_we;
        own_adr = m0_adr;
        own_dat = m0_dat_i;
      end
      ARB_OWN1: begin
        own_cyc = m1_cyc;
        own_stb = m1_stb;
        own_we  = m1_we;
        own_adr = m1_adr;
        own_dat = m1_dat_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    pick    = OWNER_M0;
    case (state_q)
      ARB_IDLE: begin
        if (req != 2'b00) begin
          if (req == 2'b11) pick = (rr_q == OWNER_M1) ? OWNER_M0 : OWNER_M1;
          else              pick = req[1];
          state_d = (pick == OWNER_M1) ? ARB_OWN1 : ARB_OWN0;
          rr_d    = pick;
        end
      end
      ARB_OWN0: if (!m0_cyc || tmo_hit) state_d = ARB_IDLE;
      ARB_OWN1: if (!m1_cyc || tmo_hit) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      rr_q    <= RR_RESET;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

`ifdef EFB_WB_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic [1:0] blk_q, blk_d;
  logic       owner;

  assign owner   = (state_q == ARB_OWN1) ? OWNER_M1 : OWNER_M0;
  assign tmo_hit = (state_q != ARB_IDLE) && (tmo_cnt_q == 8'(TIMEOUT_CYCLES));
  assign req     = {m1_cyc & ~blk_q[1], m0_cyc & ~blk_q[0]};

  // An aborted requester stays locked out until it has dropped cyc once
  always_comb begin
    tmo_cnt_d = 8'd0;
    if ((state_d == state_q) && own_stb && !s_ack) tmo_cnt_d = tmo_cnt_q + 8'd1;
    blk_d = blk_q & {m1_cyc, m0_cyc};
    if (tmo_hit) blk_d[owner] = 1'b1;
  end

  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= 8'd0;
      blk_q     <= 2'b00;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      blk_q     <= blk_d;
    end
  end

  assign m0_err = tmo_hit && (state_q == ARB_OWN0);
  assign m1_err = tmo_hit && (state_q == ARB_OWN1);
`else
  assign tmo_hit = 1'b0;
  assign req     = {m1_cyc, m0_cyc};
  assign m0_err  = 1'b0;
  assign m1_err  = 1'b0;
`endif

  assign s_cyc   = own_cyc & ~tmo_hit;
  assign s_stb   = own_stb & ~tmo_hit;
  assign s_we    = own_we;
  assign s_adr   = own_adr;
  assign s_dat_o = own_dat;

  assign m0_ack   = (state_q == ARB_OWN0) && s_ack && !tmo_hit;
  assign m1_ack   = (state_q == ARB_OWN1) && s_ack && !tmo_hit;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt      = {state_q == ARB_OWN1, state_q == ARB_OWN0};

endmodule
`default_nettype wire

// File: tb/tb_efb_wb_arb.sv
`default_nettype none
// Self-checking bench for efb_wb_arb: directed scenarios plus randomized
// wishbone traffic compared every cycle against a behavioural model.
module tb_efb_wb_arb;

  localparam int unsigned TMO = 4;
`ifdef EFB_WB_ARB_TIMEOUT_EN
  localparam bit TMO_EN  = 1'b1;
  localparam int DLY_MAX = 5;
`else
  localparam bit TMO_EN  = 1'b0;
  localparam int DLY_MAX = 3;
`endif

  logic       xclk  = 1'b0;
  logic       rst_n = 1'b0;
  logic       mcyc[2], mstb[2], mwe[2];
  logic [7:0] madr[2], mdat[2];
  logic [7:0] sdat;
  logic       sack;
  logic [7:0] m0_dat_o, m1_dat_o, s_adr, s_dat_o;
  logic       m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we;
  logic [1:0] gnt;

  int total = 0;
  int bad   = 0;

  efb_wb_arb #(.TIMEOUT_CYCLES(TMO)) dut (
    .xclk(xclk), .rst_n(rst_n),
    .m0_cyc(mcyc[0]), .m0_stb(mstb[0]), .m0_we(mwe[0]), .m0_adr(madr[0]),
    .m0_dat_i(mdat[0]), .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(mcyc[1]), .m1_stb(mstb[1]), .m1_we(mwe[1]), .m1_adr(madr[1]),
    .m1_dat_i(mdat[1]), .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
    .s_dat_i(sdat), .s_ack(sack), .gnt(gnt)
  );

  always #5 xclk = ~xclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: owner 0=none 1=m0 2=m1; rr = index served last; blocked = aborted
  int owner = 0, n_owner = 0;
  bit rr = 1'b1, n_rr = 1'b1;
  int wait_cnt = 0, n_wait_cnt = 0;
  bit blocked[2] = '{1'b0, 1'b0};
  bit n_blocked[2];
  logic smp_ack[2], smp_err[2], smp_stb, smp_sack;

  always @(negedge xclk) begin : p_cmp
    int o;
    bit hit, r0, r1;
    logic [1:0] e_gnt;
    o     = (owner == 0) ? 0 : owner - 1;
    hit   = TMO_EN && (owner != 0) && (wait_cnt == TMO);
    e_gnt = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
    chk("gnt",      gnt,     e_gnt);
    chk("s_cyc",    s_cyc,   (owner != 0) ? (mcyc[o] & ~hit) : 1'b0);
    chk("s_stb",    s_stb,   (owner != 0) ? (mstb[o] & ~hit) : 1'b0);
    chk("s_we",     s_we,    (owner != 0) ? mwe[o] : 1'b0);
    chk("s_adr",    s_adr,   (owner != 0) ? madr[o] : 8'h00);
    chk("s_dat_o",  s_dat_o, (owner != 0) ? mdat[o] : 8'h00);
    chk("m0_ack",   m0_ack,  (owner == 1) && sack && !hit);
    chk("m1_ack",   m1_ack,  (owner == 2) && sack && !hit);
    chk("m0_err",   m0_err,  (owner == 1) && hit);
    chk("m1_err",   m1_err,  (owner == 2) && hit);
    chk("m0_dat_o", m0_dat_o, sdat);
    chk("m1_dat_o", m1_dat_o, sdat);
    smp_ack[0] = m0_ack;
    smp_ack[1] = m1_ack;
    smp_err[0] = m0_err;
    smp_err[1] = m1_err;
    smp_stb    = s_stb;
    smp_sack   = sack;

    for (int i = 0; i < 2; i++) n_blocked[i] = blocked[i] && mcyc[i];
    n_rr = rr;
    if (owner == 0) begin
      r0 = mcyc[0] && !blocked[0];
      r1 = mcyc[1] && !blocked[1];
      if (r0 && r1)  n_owner = rr ? 1 : 2;
      else if (r0)   n_owner = 1;
      else if (r1)   n_owner = 2;
      else           n_owner = 0;
      if (n_owner != 0) n_rr = (n_owner == 2);
    end else begin
      n_owner = owner;
      if (hit) begin
        n_owner      = 0;
        n_blocked[o] = 1'b1;
      end else if (!mcyc[o]) begin
        n_owner = 0;
      end
    end
    n_wait_cnt = (owner != 0 && n_owner == owner && mstb[o] && !sack) ? wait_cnt + 1 : 0;
  end

  always @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= 0;
      rr         <= 1'b1;
      wait_cnt   <= 0;
      blocked[0] <= 1'b0;
      blocked[1] <= 1'b0;
    end else begin
      owner      <= n_owner;
      rr         <= n_rr;
      wait_cnt   <= n_wait_cnt;
      blocked[0] <= n_blocked[0];
      blocked[1] <= n_blocked[1];
    end
  end

  task automatic step();
    @(posedge xclk);
    #1;
  endtask

  task automatic drop(input int i);
    mcyc[i] = 1'b0;
    mstb[i] = 1'b0;
  endtask

  task automatic raise(input int i, input logic we, input logic [7:0] adr, input logic [7:0] dat);
    mcyc[i] = 1'b1;
    mstb[i] = 1'b1;
    mwe[i]  = we;
    madr[i] = adr;
    mdat[i] = dat;
  endtask

  int ntx[2];
  int w, dly;

  initial begin
    for (int i = 0; i < 2; i++) begin
      drop(i);
      mwe[i] = 1'b0; madr[i] = 8'h00; mdat[i] = 8'h00; ntx[i] = 0;
    end
    sack = 1'b0;
    sdat = 8'h00;
    w = 0; dly = 0;

    // reset state
    repeat (2) @(posedge xclk);
    @(negedge xclk);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    step();
    rst_n = 1'b1;

    // m0 write 41/04, slave acks after 3 wait cycles
    raise(0, 1'b1, 8'h41, 8'h04);
    @(negedge xclk);
    chk("t1_idle_gnt", gnt, 2'b00);
    chk("t1_idle_stb", s_stb, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge xclk);
      chk("t1_gnt", gnt, 2'b01);
      chk("t1_adr", s_adr, 8'h41);
      chk("t1_we", s_we, 1'b1);
      chk("t1_noack", m0_ack, 1'b0);
    end
    step(); sack = 1'b1;
    @(negedge xclk);
    chk("t1_ack", m0_ack, 1'b1);
    chk("t1_dat", s_dat_o, 8'h04);
    step(); sack = 1'b0; drop(0);
    @(negedge xclk);
    chk("t1_ack_pulse", m0_ack, 1'b0);
    step();
    @(negedge xclk);
    chk("t1_end_gnt", gnt, 2'b00);

    // simultaneous request right after reset: m0 first, one idle gap, m1
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    raise(0, 1'b0, 8'h01, 8'h00);
    raise(1, 1'b0, 8'h10, 8'h00);
    step(); sack = 1'b1;
    @(negedge xclk);
    chk("t2_gnt_m0", gnt, 2'b01);
    chk("t2_m1_noack", m1_ack, 1'b0);
    step(); sack = 1'b0; drop(0);
    step();
    @(negedge xclk);
    chk("t2_gap", gnt, 2'b00);
    step();
    @(negedge xclk);
    chk("t2_gnt_m1", gnt, 2'b10);
    chk("t2_adr", s_adr, 8'h10);
    step(); sack = 1'b1;
    step(); sack = 1'b0; drop(1);
    repeat (2) step();

    // m1 burst of three reads while m0 stalls
    sdat = 8'hA5;
    raise(1, 1'b0, 8'h73, 8'h00);
    step();
    raise(0, 1'b1, 8'h55, 8'h66);
    for (int r = 0; r < 3; r++) begin
      @(negedge xclk);
      chk("t3_gnt", gnt, 2'b10);
      chk("t3_adr", s_adr, 8'h73);
      chk("t3_m0_stall", m0_ack, 1'b0);
      step(); sack = 1'b1;
      @(negedge xclk);
      chk("t3_m1_ack", m1_ack, 1'b1);
      chk("t3_m1_dat", m1_dat_o, 8'hA5);
      chk("t3_m0_noack", m0_ack, 1'b0);
      step(); sack = 1'b0;
      if (r == 2) drop(1);
    end
    step();
    @(negedge xclk);
    chk("t3_gap", gnt, 2'b00);
    step();
    @(negedge xclk);
    chk("t3_m0_gnt", gnt, 2'b01);
    step(); sack = 1'b1;
    step(); sack = 1'b0; drop(0);
    repeat (2) step();

    // spurious ack while idle
    sack = 1'b1;
    @(negedge xclk);
    chk("t4_m0_ack", m0_ack, 1'b0);
    chk("t4_m1_ack", m1_ack, 1'b0);
    step(); sack = 1'b0;

    // async reset in the middle of an m1 read
    raise(1, 1'b0, 8'h20, 8'h00);
    step();
    @(negedge xclk);
    chk("t5_gnt", gnt, 2'b10);
    #2; rst_n = 1'b0; sack = 1'b1;
    #1;
    chk("t5_rst_gnt", gnt, 2'b00);
    chk("t5_rst_cyc", s_cyc, 1'b0);
    chk("t5_rst_stb", s_stb, 1'b0);
    chk("t5_rst_ack", m1_ack, 1'b0);
    raise(0, 1'b0, 8'h21, 8'h00);
    step(); rst_n = 1'b1; sack = 1'b0;
    step();
    @(negedge xclk);
    chk("t5_first_gnt", gnt, 2'b01);
    sack = 1'b1;
    step(); sack = 1'b0; drop(0);
    repeat (2) step();
    sack = 1'b1;
    step(); sack = 1'b0; drop(1);
    repeat (2) step();

`ifdef EFB_WB_ARB_TIMEOUT_EN
    // slave never acks: abort after TMO wait cycles, lockout until cyc drops
    raise(0, 1'b0, 8'h33, 8'h00);
    step();
    for (int k = 0; k < 4; k++) begin
      @(negedge xclk);
      chk("t6_wait_stb", s_stb, 1'b1);
      chk("t6_wait_err", m0_err, 1'b0);
      step();
    end
    @(negedge xclk);
    chk("t6_err", m0_err, 1'b1);
    chk("t6_stb_mask", s_stb, 1'b0);
    chk("t6_cyc_mask", s_cyc, 1'b0);
    chk("t6_noack", m0_ack, 1'b0);
    step();
    @(negedge xclk);
    chk("t6_idle", gnt, 2'b00);
    chk("t6_err_pulse", m0_err, 1'b0);
    step();
    @(negedge xclk);
    chk("t6_locked", gnt, 2'b00);
    drop(0);
    step();
    raise(0, 1'b0, 8'h33, 8'h00);
    step();
    @(negedge xclk);
    chk("t6_regrant", gnt, 2'b01);
    sack = 1'b1;
    step(); sack = 1'b0; drop(0);
    repeat (2) step();
`endif

    // randomized traffic
    for (int cy = 0; cy < 3000; cy++) begin
      step();
      sdat = 8'($urandom);
      if (cy >= 1500 && cy < 1502) begin
        rst_n = 1'b0;
        drop(0); drop(1);
        sack = 1'b0; w = 0;
        continue;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (!mcyc[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            raise(i, 1'($urandom), 8'($urandom), 8'($urandom));
            ntx[i] = $urandom_range(1, 3);
          end
        end else if (smp_err[i]) begin
          drop(i);
        end else if (mstb[i] && smp_ack[i]) begin
          ntx[i]--;
          if (ntx[i] == 0) drop(i);
          else begin
            mstb[i] = ($urandom_range(0, 3) != 0);
            mwe[i]  = 1'($urandom);
            madr[i] = 8'($urandom);
            mdat[i] = 8'($urandom);
          end
        end else if (!mstb[i]) begin
          mstb[i] = 1'b1;
        end
      end
      if (smp_stb && !smp_sack) begin
        w++;
        sack = (w > dly);
      end else begin
        w    = 0;
        dly  = $urandom_range(0, DLY_MAX);
        sack = ($urandom_range(0, 15) == 0);
      end
    end

    drop(0); drop(1); sack = 1'b0;
    repeat (3) step();
    @(negedge xclk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
